kernel_irq_sched: RTL

- Collects done-interrupts from NUM_KERNELS accelerator kernels and presents them to the host one at a time on a single interrupt line, with the serviced kernel's index.
- Synchronizes and edge-detects every request and latches it as pending. Masked, round-robin arbitration selects the next kernel. Holds the interrupt until the host acknowledges, then returns an ack pulse to that kernel.
- Sits between the kernel array and the DMA/host interrupt path. Replaces per-kernel interrupt lines.

---
 rtl/kernel_irq_pkg.sv | 14 +
 rtl/kernel_irq_sched_rr_arbiter.sv | 27 ++
 rtl/kernel_irq_sched.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/kernel_irq_pkg.sv
// Shared types and default constants for the kernel interrupt scheduler.
package kernel_irq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAssert,
    StClear,
    StGap
  } irq_state_e;

  localparam int unsigned DefSyncStages = 3;
  localparam int unsigned DefAckTimeout = 1024;

endpackage

// File: rtl/kernel_irq_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping to 0.
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic [IdxW-1:0]   grant_idx,
  output logic              grant_valid
);

  logic [IdxW-1:0] idx;

  always_comb begin
    idx         = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      idx = IdxW'((32'(ptr) + off) % NumReq);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/kernel_irq_sched.sv
// Funnels per-kernel done events onto one host interrupt line, one kernel at a time,
// with round-robin selection, host acknowledge handshake and a sticky ack timeout.
module kernel_irq_sched
  import kernel_irq_pkg::*;
#(
  parameter int unsigned NUM_KERNELS = 4,
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned ACK_TIMEOUT = DefAckTimeout,
  parameter int unsigned ID_W        = $clog2(NUM_KERNELS)
) (
  input  logic                   dma_axi_aclk,
  input  logic                   dma_axi_areset,
  input  logic [NUM_KERNELS-1:0] kernel_int,
  input  logic [NUM_KERNELS-1:0] irq_mask,
  input  logic                   host_ack,
  input  logic                   err_clr,
  output logic                   kernel_irq,
  output logic [ID_W-1:0]        irq_id,
  output logic [NUM_KERNELS-1:0] irq_pending,
  output logic [NUM_KERNELS-1:0] kernel_ack,
  output logic [NUM_KERNELS-1:0] overflow,
  output logic                   timeout_err
);

  localparam int unsigned   CntW   = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ACK_TIMEOUT - 1);

  // Bit NUM_KERNELS of the sync path carries host_ack.
  logic [SYNC_STAGES-1:0][NUM_KERNELS:0] sync_q;
  logic [NUM_KERNELS:0]                  hist_q, edge_q;

  irq_state_e             state_q, state_d;
  logic [ID_W-1:0]        irq_id_q, irq_id_d, ptr_q, ptr_d, win_idx;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [NUM_KERNELS-1:0] pending_q, pending_d, overflow_q, overflow_d;
  logic [NUM_KERNELS-1:0] kernel_ack_q, kernel_ack_d, clr_vec, eligible, id_onehot;
  logic [NUM_KERNELS-1:0] kint_edge;
  logic                   timeout_q, timeout_d, timeout_set, kernel_irq_q, ack_edge, win_valid;

  // Edge detect is registered so an event lands in pending SYNC_STAGES+1 edges after capture.
  always_ff @(posedge dma_axi_aclk or posedge dma_axi_areset) begin
    if (dma_axi_areset) begin
      sync_q <= '0;
      hist_q <= '0;
      edge_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {host_ack, kernel_int}};
      hist_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
    end
  end

  assign kint_edge = edge_q[NUM_KERNELS-1:0];
  assign ack_edge  = edge_q[NUM_KERNELS];
  assign eligible  = pending_q & ~irq_mask;
  assign id_onehot = NUM_KERNELS'(1) << irq_id_q;

  rr_arbiter #(
    .NumReq (NUM_KERNELS),
    .IdxW   (ID_W)
  ) u_rr_arbiter (
    .req         (eligible),
    .ptr         (ptr_q),
    .grant_idx   (win_idx),
    .grant_valid (win_valid)
  );

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    clr_vec  = '0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (win_valid) begin
          irq_id_d = win_idx;
          state_d  = StAssert;
        end
      end
      StAssert: begin
        if (ack_edge) begin
          state_d = StClear;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StClear: begin
        clr_vec = id_onehot;
        ptr_d   = (irq_id_q == ID_W'(NUM_KERNELS - 1)) ? '0 : irq_id_q + 1'b1;
        cnt_d   = '0;
        state_d = StGap;
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Fires once on reaching the limit so err_clr can clear it while still stuck in ASSERT.
  assign timeout_set = (ACK_TIMEOUT != 0) && (state_d == StAssert) && (cnt_d == CntMax) &&
                       !((state_q == StAssert) && (cnt_q == CntMax));

  always_comb begin
    pending_d    = (pending_q & ~clr_vec) | kint_edge;
    overflow_d   = (err_clr ? '0 : overflow_q) | (kint_edge & pending_q & ~clr_vec);
    timeout_d    = (err_clr ? 1'b0 : timeout_q) | timeout_set;
    kernel_ack_d = (state_d == StClear) ? id_onehot : '0;
  end

  always_ff @(posedge dma_axi_aclk or posedge dma_axi_areset) begin
    if (dma_axi_areset) begin
      state_q      <= StIdle;
      irq_id_q     <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      pending_q    <= '0;
      overflow_q   <= '0;
      timeout_q    <= 1'b0;
      kernel_irq_q <= 1'b0;
      kernel_ack_q <= '0;
    end else begin
      state_q      <= state_d;
      irq_id_q     <= irq_id_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      timeout_q    <= timeout_d;
      kernel_irq_q <= (state_d == StAssert);
      kernel_ack_q <= kernel_ack_d;
    end
  end

  assign kernel_irq  = kernel_irq_q;
  assign irq_id      = irq_id_q;
  assign irq_pending = pending_q;
  assign kernel_ack  = kernel_ack_q;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_q;

endmodule
